// File: rtl/cs_pkg.sv
// Shared definitions for the chip-select map: overlay FSM encoding, default
// window tables and the page test used by the video/sound write strobes.
package cs_pkg;

   typedef enum logic [1:0] {
      OVL_ON    = 2'd0,
      OVL_ARMED = 2'd1,
      OVL_OFF   = 2'd2
   } ovl_state_e;

   localparam int CS_MAX_NCH = 16;

   // Default tables are sized for the largest map; instances slice what they need.
   localparam logic [CS_MAX_NCH*16-1:0] CS_WIN_BASE_DEF = '0;
   localparam logic [CS_MAX_NCH*16-1:0] CS_WIN_MASK_DEF = '0;

   localparam logic [255:0] CS_SND_PG_DEF = (256'b1 << 8'hFD) | (256'b1 << 8'hFE) |
                                            (256'b1 << 8'hFF) | (256'b1 << 8'hA1) |
                                            (256'b1 << 8'hA2) | (256'b1 << 8'hA3);

   function automatic logic page_hit(input logic [7:0] page,
                                     input logic [7:0] ref_page,
                                     input logic [7:0] care);
      return ((page ^ ref_page) & care) == 8'h00;
   endfunction

endpackage

// File: rtl/cs_win_match.sv
// Combinational window decoder: masked compare per window, lowest index wins.
module cs_win_match
   import cs_pkg::*;
#(
   parameter int                NCH      = 8,
   parameter logic [NCH*16-1:0] WIN_BASE = CS_WIN_BASE_DEF[NCH*16-1:0],
   parameter logic [NCH*16-1:0] WIN_MASK = CS_WIN_MASK_DEF[NCH*16-1:0]
)(
   input  logic [15:0]    addr_i,
   output logic [NCH-1:0] sel_o,
   output logic           any_o
);

   logic [NCH-1:0] raw_hit;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_win
      assign raw_hit[gi] = ((addr_i ^ WIN_BASE[gi*16 +: 16]) & WIN_MASK[gi*16 +: 16]) == 16'h0000;
   end

   always_comb begin
      logic found;
      found = 1'b0;
      sel_o = '0;
      for (int i = 0; i < NCH; i++) begin
         if (raw_hit[i] && !found) begin
            sel_o[i] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any_o = |raw_hit;

endmodule

// File: rtl/cs_map.sv
// Bus-cycle chip-select map: latches the window decode at the start of each
// bus cycle, runs the boot overlay FSM and times out unmapped accesses.
module cs_map
   import cs_pkg::*;
#(
   parameter int                NCH          = 8,
   parameter logic [NCH*16-1:0] WIN_BASE     = CS_WIN_BASE_DEF[NCH*16-1:0],
   parameter logic [NCH*16-1:0] WIN_MASK     = CS_WIN_MASK_DEF[NCH*16-1:0],
   parameter logic [NCH-1:0]    WIN_IO       = '0,
   parameter int                RAM_WIN      = 0,
   parameter int                ROM_WIN      = 1,
   parameter int                OVL_EXIT_WIN = 1,
   parameter int                OVL_EN       = 1,
   parameter logic [7:0]        VID_PAGE     = 8'h3F,
   parameter logic [7:0]        VID_PMASK    = 8'hBF,
   parameter logic [15:0]       VID_NIB      = 16'hFCFC,
   parameter logic [255:0]      SND_PG       = CS_SND_PG_DEF,
   parameter int                BERR_TO      = 64
)(
   input  logic           CLK,
   input  logic           nRES,
   input  logic [15:0]    A,
   input  logic           nWE,
   input  logic           BACT,
   output logic [NCH-1:0] SEL,
   output logic           RAMCS,
   output logic           ROMCS,
   output logic           IOCS,
   output logic           IOPWCS,
   output logic           VIDWR,
   output logic           SNDWR,
   output logic           BERR,
   output logic           Overlay
);

   localparam logic [7:0] BERR_LIM = 8'(BERR_TO);

   logic [NCH-1:0] win_sel;
   logic           win_any;
   logic [NCH-1:0] sel_eff;
   logic           cap;

   logic [NCH-1:0] sel_q,    sel_d;
   logic           ramcs_q,  ramcs_d;
   logic           romcs_q,  romcs_d;
   logic           iocs_q,   iocs_d;
   logic           iopwcs_q, iopwcs_d;
   logic           vidwr_q,  vidwr_d;
   logic           sndwr_q,  sndwr_d;
   logic           berr_q,   berr_d;
   logic           unm_q,    unm_d;
   logic [7:0]     cnt_q,    cnt_d;
   logic           bact_q;
   ovl_state_e     ovl_state_q;
   logic           ovl_q;

   cs_win_match #(
      .NCH      (NCH),
      .WIN_BASE (WIN_BASE),
      .WIN_MASK (WIN_MASK)
   ) u_match (
      .addr_i (A),
      .sel_o  (win_sel),
      .any_o  (win_any)
   );

   // bact_q resets high so a BACT still asserted across reset is not captured.
   assign cap = BACT & ~bact_q;

   always_comb begin
      sel_eff = win_sel;
      if (ovl_q && win_sel[RAM_WIN]) begin
         sel_eff          = '0;
         sel_eff[ROM_WIN] = 1'b1;
      end
   end

   always_comb begin
      logic wr;
      logic page_ok;
      wr       = ~nWE;
      page_ok  = page_hit(A[15:8], VID_PAGE, VID_PMASK);
      sel_d    = sel_q;
      ramcs_d  = ramcs_q;
      romcs_d  = romcs_q;
      iocs_d   = iocs_q;
      iopwcs_d = iopwcs_q;
      vidwr_d  = vidwr_q;
      sndwr_d  = sndwr_q;
      berr_d   = berr_q;
      unm_d    = unm_q;
      cnt_d    = cnt_q;
      if (!BACT) begin
         sel_d    = '0;
         ramcs_d  = 1'b0;
         romcs_d  = 1'b0;
         iocs_d   = 1'b0;
         iopwcs_d = 1'b0;
         vidwr_d  = 1'b0;
         sndwr_d  = 1'b0;
         berr_d   = 1'b0;
         unm_d    = 1'b0;
         cnt_d    = 8'd0;
      end else if (cap) begin
         sel_d    = sel_eff;
         ramcs_d  = sel_eff[RAM_WIN];
         romcs_d  = sel_eff[ROM_WIN];
         iopwcs_d = sel_eff[RAM_WIN] & wr;
         vidwr_d  = sel_eff[RAM_WIN] & wr & page_ok & VID_NIB[A[7:4]];
         sndwr_d  = sel_eff[RAM_WIN] & wr & page_ok & SND_PG[A[7:0]];
         iocs_d   = (|(sel_eff & WIN_IO)) | vidwr_d;
         berr_d   = 1'b0;
         unm_d    = ~win_any;
         cnt_d    = 8'd0;
      end else if (unm_q && cnt_q != BERR_LIM) begin
         // Counter saturates at the limit; BERR then holds until BACT drops.
         cnt_d = cnt_q + 8'd1;
         if (cnt_d == BERR_LIM) begin
            berr_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         sel_q    <= '0;
         ramcs_q  <= 1'b0;
         romcs_q  <= 1'b0;
         iocs_q   <= 1'b0;
         iopwcs_q <= 1'b0;
         vidwr_q  <= 1'b0;
         sndwr_q  <= 1'b0;
         berr_q   <= 1'b0;
         unm_q    <= 1'b0;
         cnt_q    <= 8'd0;
         bact_q   <= 1'b1;
      end else begin
         sel_q    <= sel_d;
         ramcs_q  <= ramcs_d;
         romcs_q  <= romcs_d;
         iocs_q   <= iocs_d;
         iopwcs_q <= iopwcs_d;
         vidwr_q  <= vidwr_d;
         sndwr_q  <= sndwr_d;
         berr_q   <= berr_d;
         unm_q    <= unm_d;
         cnt_q    <= cnt_d;
         bact_q   <= BACT;
      end
   end

   // The exit test uses the un-remapped decode: only a real ROM-window access leaves overlay.
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         ovl_state_q <= (OVL_EN != 0) ? OVL_ON : OVL_OFF;
         ovl_q       <= (OVL_EN != 0);
      end else begin
         case (ovl_state_q)
            OVL_ON: begin
               ovl_q <= 1'b1;
               if (cap && win_sel[OVL_EXIT_WIN]) begin
                  ovl_state_q <= OVL_ARMED;
               end
            end
            OVL_ARMED: begin
               if (!BACT) begin
                  ovl_state_q <= OVL_OFF;
                  ovl_q       <= 1'b0;
               end
            end
            default: begin
               ovl_state_q <= OVL_OFF;
               ovl_q       <= 1'b0;
            end
         endcase
      end
   end

   assign SEL     = sel_q;
   assign RAMCS   = ramcs_q;
   assign ROMCS   = romcs_q;
   assign IOCS    = iocs_q;
   assign IOPWCS  = iopwcs_q;
   assign VIDWR   = vidwr_q;
   assign SNDWR   = sndwr_q;
   assign BERR    = berr_q;
   assign Overlay = ovl_q;

endmodule

// File: tb/tb_cs_map.sv
// Scoreboard bench for cs_map: a reference decode model pushes the expected
// selects at each capture; the DUT outputs are popped and compared after it.
module tb_cs_map;

   localparam int           NCH    = 8;
   localparam logic [127:0] T_BASE = {{5{16'hFFFF}}, 16'h5000, 16'h4000, 16'h0000};
   localparam logic [127:0] T_MASK = {{5{16'hFFFF}}, 16'hF000, 16'hF000, 16'hC000};
   localparam logic [7:0]   T_IO   = 8'b0000_0100;
   localparam int           T_BERR = 64;

   typedef struct packed {
      logic [7:0] sel;
      logic       ram;
      logic       rom;
      logic       io;
      logic       iopw;
      logic       vid;
      logic       snd;
      logic       berr;
      logic       ovl;
      logic       unm;
   } exp_t;

   logic           CLK = 1'b0;
   logic           nRES = 1'b0;
   logic [15:0]    A = 16'h0000;
   logic           nWE = 1'b1;
   logic           BACT = 1'b0;
   logic [NCH-1:0] SEL;
   logic           RAMCS, ROMCS, IOCS, IOPWCS, VIDWR, SNDWR, BERR, Overlay;

   int   checks = 0;
   int   failures = 0;
   int   m_state = 0;   // 0 on, 1 armed, 2 off
   exp_t exp_q[$];

   cs_map #(
      .NCH      (NCH),
      .WIN_BASE (T_BASE),
      .WIN_MASK (T_MASK),
      .WIN_IO   (T_IO),
      .BERR_TO  (T_BERR)
   ) dut (
      .CLK     (CLK),
      .nRES    (nRES),
      .A       (A),
      .nWE     (nWE),
      .BACT    (BACT),
      .SEL     (SEL),
      .RAMCS   (RAMCS),
      .ROMCS   (ROMCS),
      .IOCS    (IOCS),
      .IOPWCS  (IOPWCS),
      .VIDWR   (VIDWR),
      .SNDWR   (SNDWR),
      .BERR    (BERR),
      .Overlay (Overlay)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cmp_out(input string tag, input exp_t e);
      check_eq({tag, ".SEL"},     32'(SEL),     32'(e.sel));
      check_eq({tag, ".RAMCS"},   32'(RAMCS),   32'(e.ram));
      check_eq({tag, ".ROMCS"},   32'(ROMCS),   32'(e.rom));
      check_eq({tag, ".IOCS"},    32'(IOCS),    32'(e.io));
      check_eq({tag, ".IOPWCS"},  32'(IOPWCS),  32'(e.iopw));
      check_eq({tag, ".VIDWR"},   32'(VIDWR),   32'(e.vid));
      check_eq({tag, ".SNDWR"},   32'(SNDWR),   32'(e.snd));
      check_eq({tag, ".BERR"},    32'(BERR),    32'(e.berr));
      check_eq({tag, ".Overlay"}, 32'(Overlay), 32'(e.ovl));
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e     = '0;
      e.ovl = (m_state != 2);
      return e;
   endfunction

   // Reference decode; also advances the overlay model on an exit-window hit.
   function automatic exp_t model(input logic [15:0] a, input logic we);
      exp_t         e;
      int           hit;
      logic [127:0] base, mask;
      logic [255:0] snd;
      logic [15:0]  nib;
      logic         page;
      base = T_BASE;
      mask = T_MASK;
      snd  = (256'b1 << 8'hFD) | (256'b1 << 8'hFE) | (256'b1 << 8'hFF) |
             (256'b1 << 8'hA1) | (256'b1 << 8'hA2) | (256'b1 << 8'hA3);
      nib  = 16'hFCFC;
      hit  = -1;
      for (int i = 0; i < NCH; i++) begin
         if (hit < 0 && ((a ^ base[i*16 +: 16]) & mask[i*16 +: 16]) == 16'h0) hit = i;
      end
      e     = '0;
      e.ovl = (m_state != 2);
      if (hit == 1 && m_state == 0) m_state = 1;
      if (hit == 0 && e.ovl) hit = 1;
      page = ((a[15:8] ^ 8'h3F) & 8'hBF) == 8'h00;
      if (hit < 0) begin
         e.unm = 1'b1;
      end else begin
         e.sel[hit] = 1'b1;
         e.ram  = (hit == 0);
         e.rom  = (hit == 1);
         e.iopw = e.ram & we;
         e.vid  = e.ram & we & page & nib[a[7:4]];
         e.snd  = e.ram & we & page & snd[a[7:0]];
         e.io   = (hit == 2) | e.vid;
      end
      return e;
   endfunction

   task automatic bus_cycle(input logic [15:0] a, input logic we, input int hold,
                            input logic [15:0] a_mid);
      exp_t e;
      @(negedge CLK);
      A    = a;
      nWE  = ~we;
      BACT = 1'b1;
      exp_q.push_back(model(a, we));
      @(negedge CLK);
      e = exp_q.pop_front();
      $display("cycle A=%h we=%0d exp_sel=%b unmapped=%0d", a, we, e.sel, e.unm);
      cmp_out("capture", e);
      A = a_mid;
      for (int j = 1; j <= hold; j++) begin
         @(negedge CLK);
         e.berr = e.unm && (j >= T_BERR);
         cmp_out("hold", e);
      end
      BACT = 1'b0;
      nWE  = 1'b1;
      if (m_state == 1) m_state = 2;
      @(negedge CLK);
      cmp_out("idle", idle_exp());
   endtask

   task automatic do_reset();
      nRES = 1'b0;
      BACT = 1'b0;
      m_state = 0;
      exp_q.delete();
      repeat (2) @(negedge CLK);
      cmp_out("reset", idle_exp());
      nRES = 1'b1;
      @(negedge CLK);
      cmp_out("post_reset", idle_exp());
   endtask

   initial begin
      do_reset();
      bus_cycle(16'h0000, 1'b0, 2, 16'h0000);   // overlay: RAM window reads as ROM
      bus_cycle(16'h4000, 1'b0, 2, 16'h4000);   // arms, leaves overlay at BACT low
      check_eq("overlay_off", 32'(Overlay), 32'd0);
      bus_cycle(16'h0000, 1'b0, 1, 16'h0000);
      bus_cycle(16'h3FA2, 1'b1, 1, 16'h3FA2);
      bus_cycle(16'h3F80, 1'b1, 1, 16'h3F80);
      bus_cycle(16'h5000, 1'b0, 1, 16'h5000);
      bus_cycle(16'h5000, 1'b1, 1, 16'h5000);
      bus_cycle(16'h4000, 1'b0, 4, 16'h5000);   // address moves mid-cycle
      bus_cycle(16'h8000, 1'b0, 100, 16'h8000); // unmapped -> bus error timeout

      // Reset while overlay is armed and BACT still high.
      do_reset();
      begin
         exp_t e;
         @(negedge CLK);
         A    = 16'h4000;
         nWE  = 1'b1;
         BACT = 1'b1;
         exp_q.push_back(model(16'h4000, 1'b0));
         @(negedge CLK);
         e = exp_q.pop_front();
         $display("cycle A=%h we=0 exp_sel=%b (armed before reset)", 16'h4000, e.sel);
         cmp_out("armed", e);
      end
      @(negedge CLK);
      #2 nRES = 1'b0;
      m_state = 0;
      #1 cmp_out("async_reset", idle_exp());
      @(negedge CLK);
      nRES = 1'b1;
      A = 16'h0000;
      repeat (3) begin
         @(negedge CLK);
         cmp_out("no_capture", idle_exp());
      end
      BACT = 1'b0;
      @(negedge CLK);
      cmp_out("bact_low", idle_exp());
      bus_cycle(16'h0000, 1'b0, 1, 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
